// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts one command, drives the operand-register loads and the ALU enable, then captures and returns the result.
// Optional feature macro ALU_SEQ_FLAGS_EN: registered zero/negative flags on the captured result (tied to 0 when undefined).
module alu_sequencer #(
  parameter int WIDTH    = 8,
  parameter int ALU_WAIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_opcode,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [WIDTH-1:0] dataAIn,
  output logic [WIDTH-1:0] dataBIn,
  output logic             loadA,
  output logic             loadB,
  output logic             sendALU,
  output logic [3:0]       opcode,
  input  logic [WIDTH-1:0] resultIn,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_zero,
  output logic             res_neg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EXEC = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(ALU_WAIT);

  state_t     stateR;
  state_t     nextStateS;
  logic [3:0] waitCntR;
  logic       acceptS;
  logic       captureS;
  logic       cmdReadyS;
  logic       loadS;
  logic       sendS;
  logic       resValidS;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateR <= IDLE;
    end else begin
      stateR <= nextStateS;
    end
  end

  // Next-state decode; handshakes use the registered ready/valid so nothing depends on an unregistered output.
  always_comb begin
    nextStateS = stateR;
    acceptS    = 1'b0;
    captureS   = 1'b0;
    case (stateR)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          nextStateS = LOAD;
          acceptS    = 1'b1;
        end else begin
          nextStateS = IDLE;
        end
      end
      LOAD: nextStateS = EXEC;
      EXEC: begin
        if (waitCntR == 4'd0) begin
          nextStateS = DONE;
          captureS   = 1'b1;
        end else begin
          nextStateS = EXEC;
        end
      end
      DONE: begin
        if (res_valid && res_ready) begin
          nextStateS = IDLE;
        end else begin
          nextStateS = DONE;
        end
      end
      default: nextStateS = IDLE;
    endcase
  end

  // Output decode from the upcoming state, so the registered strobes line up with the state they belong to.
  always_comb begin
    cmdReadyS = (nextStateS == IDLE);
    loadS     = (nextStateS == LOAD);
    sendS     = (nextStateS == EXEC);
    resValidS = (nextStateS == DONE);
  end

  // Registered strobes, latched command fields and captured result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_ready <= 1'b0;
      loadA     <= 1'b0;
      loadB     <= 1'b0;
      sendALU   <= 1'b0;
      res_valid <= 1'b0;
      opcode    <= 4'd0;
      dataAIn   <= {WIDTH{1'b0}};
      dataBIn   <= {WIDTH{1'b0}};
      res_data  <= {WIDTH{1'b0}};
    end else begin
      cmd_ready <= cmdReadyS;
      loadA     <= loadS;
      loadB     <= loadS;
      sendALU   <= sendS;
      res_valid <= resValidS;
      if (acceptS) begin
        opcode  <= cmd_opcode;
        dataAIn <= cmd_a;
        dataBIn <= cmd_b;
      end
      if (captureS) begin
        res_data <= resultIn;
      end
    end
  end

  // ALU settle counter: loaded while leaving LOAD, counts down in EXEC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      waitCntR <= 4'd0;
    end else if (stateR == LOAD) begin
      waitCntR <= WAIT_INIT;
    end else if ((stateR == EXEC) && (waitCntR != 4'd0)) begin
      waitCntR <= waitCntR - 4'd1;
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  function automatic logic isZero(input logic [WIDTH-1:0] v);
    return (v == {WIDTH{1'b0}});
  endfunction

  function automatic logic isNeg(input logic [WIDTH-1:0] v);
    return v[WIDTH-1];
  endfunction

  // Result flags, captured on the same edge as res_data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_zero <= 1'b0;
      res_neg  <= 1'b0;
    end else if (captureS) begin
      res_zero <= isZero(resultIn);
      res_neg  <= isNeg(resultIn);
    end
  end
`else
  assign res_zero = 1'b0;
  assign res_neg  = 1'b0;
`endif

endmodule
